x_counter_ctrl: RTL and testbench

X_COUNTER_CTRL -- requirements
Module: x_counter_ctrl

---
 rtl/x_counter_ctrl.sv | 118 +++++++++++
 tb/tb_x_counter_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_counter_ctrl.sv
// -----------------------------------------------------------------------------
// x_counter_ctrl
//
// Up/down counter with a live terminal value and three terminal behaviours:
// wrap (reload and flag overflow), saturate (hold), and one-shot (hold and
// park in a DONE state until reloaded).
//
// Ports
//   i_clk       : clock, all state updates on the rising edge
//   i_rst       : synchronous active-high reset
//   i_en        : count enable, one step per enabled cycle
//   i_up        : direction, 1 = up, 0 = down
//   i_mode      : 0 = wrap, 1 = saturate, 2 = one-shot, 3 = treated as wrap
//   i_load      : synchronous load strobe
//   i_load_val  : value taken on load
//   i_limit     : up-count terminal value (down-count terminal is 0)
//   i_clr_ovf   : clears the sticky overflow flag
//   o_count     : registered count
//   o_tc        : one-cycle pulse in the cycle after a terminal event
//   o_done      : high while the one-shot FSM is in DONE
//   o_ovf       : sticky flag, set by a wrap at the terminal value
// -----------------------------------------------------------------------------
module x_counter_ctrl #(
    parameter int unsigned       WIDTH   = 32,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic [1:0]       i_mode,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_clr_ovf,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_done,
    output logic             o_ovf
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam logic [1:0]       MODE_SAT     = 2'd1;
    localparam logic [1:0]       MODE_ONESHOT = 2'd2;
    localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;
    logic             at_tc;

    // Terminal condition uses the direction presented this cycle, so a
    // direction flip is seen immediately.
    assign at_tc = (i_up && (count_q == i_limit)) || (!i_up && (count_q == '0));

    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_set = 1'b0;

        if (i_load) begin
            // Load overrides stepping and always re-arms the one-shot.
            count_d = i_load_val;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && i_en) begin
            if (!at_tc) begin
                // Modulo arithmetic: a count above the limit simply rolls
                // through all-ones to zero without being a terminal event.
                count_d = i_up ? count_q + ONE : count_q - ONE;
            end else begin
                tc_d = 1'b1;
                case (i_mode)
                    MODE_SAT:     count_d = count_q;
                    MODE_ONESHOT: state_d = ST_DONE;
                    default: begin
                        count_d = i_up ? '0 : i_limit;
                        ovf_set = 1'b1;
                    end
                endcase
            end
        end
        // DONE (without a load) falls through: count and state hold.

        // A new overflow beats a clear arriving in the same cycle.
        ovf_d = ovf_set | (ovf_q & ~i_clr_ovf);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            count_q <= RST_VAL;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_count = count_q;
    assign o_tc    = tc_q;
    assign o_done  = (state_q == ST_DONE);
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_x_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_x_counter_ctrl
//
// Drives an 8-bit and a 32-bit instance from the same control inputs.
// Directed scenarios check hand-derived values; a randomized run compares
// both instances every cycle against a rule-level reference model.
// -----------------------------------------------------------------------------
module tb_x_counter_ctrl;

    localparam logic [31:0] RV32 = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        rst, en, up, load, clr;
    logic [1:0]  mode;
    logic [31:0] lv, lim;

    logic [7:0]  cnt8;
    logic        tc8, done8, ovf8;
    logic [31:0] cnt32;
    logic        tc32, done32, ovf32;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    x_counter_ctrl #(.WIDTH(8), .RST_VAL(8'h00)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_mode(mode),
        .i_load(load), .i_load_val(lv[7:0]), .i_limit(lim[7:0]),
        .i_clr_ovf(clr), .o_count(cnt8), .o_tc(tc8), .o_done(done8),
        .o_ovf(ovf8)
    );

    x_counter_ctrl #(.WIDTH(32), .RST_VAL(RV32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_mode(mode),
        .i_load(load), .i_load_val(lv), .i_limit(lim),
        .i_clr_ovf(clr), .o_count(cnt32), .o_tc(tc32), .o_done(done32),
        .o_ovf(ovf32)
    );

    // ------------------------------------------------------------------
    // Reference model: the counter's rules written as plain arithmetic.
    // ------------------------------------------------------------------
    typedef struct {
        longint unsigned count;
        bit              tc;
        bit              done;
        bit              ovf;
    } model_t;

    model_t m8  = '{0, 0, 0, 0};
    model_t m32 = '{0, 0, 0, 0};

    function automatic model_t model_next(input model_t m, input int w,
                                          input longint unsigned rv);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned l    = longint'(lim) & mask;
        model_t          n    = m;
        bit              wrapped = 0;
        n.tc = 0;
        if (rst) begin
            n = '{rv & mask, 0, 0, 0};
            return n;
        end
        if (load) begin
            n.count = longint'(lv) & mask;
            n.done  = 0;
        end else if (!m.done && en) begin
            if (up ? (m.count == l) : (m.count == 0)) begin
                n.tc = 1;
                if (mode == 2'd2)      n.done = 1;
                else if (mode != 2'd1) begin
                    n.count = up ? 0 : l;
                    wrapped = 1;
                end
            end else begin
                n.count = up ? (m.count + 1) & mask : (m.count - 1) & mask;
            end
        end
        if (wrapped)  n.ovf = 1;
        else if (clr) n.ovf = 0;
        return n;
    endfunction

    // One clock: inputs are held across the edge, outputs settle by #1.
    task automatic tick();
        @(posedge clk);
        #1;
        m8  = model_next(m8, 8, 64'd0);
        m32 = model_next(m32, 32, longint'(RV32));
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; up = 1; mode = 2'd0; load = 0; clr = 0;
        lv = '0; lim = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        // Reset beats a simultaneous load and enable.
        idle_inputs();
        rst = 1; load = 1; en = 1; lv = 32'h33;
        tick();
        n_checks++;
        if ({cnt8, tc8, done8, ovf8} !== {8'h00, 3'b000}) begin
            $display("FAIL reset8: got cnt=%0h tc=%b done=%b ovf=%b want 0 0 0 0",
                     cnt8, tc8, done8, ovf8);
        end else n_pass++;
        n_checks++;
        if ({cnt32, tc32, done32, ovf32} !== {RV32, 3'b000}) begin
            $display("FAIL reset32: got cnt=%0h tc=%b done=%b ovf=%b want a5 0 0 0",
                     cnt32, tc32, done32, ovf32);
        end else n_pass++;

        // Mid-count reset acts at its edge; counting resumes right after.
        idle_inputs();
        en = 1; lim = 32'd100;
        tick(); tick();
        n_checks++;
        if (cnt8 !== 8'd2) $display("FAIL precount: got %0d want 2", cnt8);
        else n_pass++;
        rst = 1;
        tick();
        n_checks++;
        if (cnt8 !== 8'd0) $display("FAIL midreset: got %0d want 0", cnt8);
        else n_pass++;
        rst = 0;
        tick();
        n_checks++;
        if (cnt8 !== 8'd1) $display("FAIL resume: got %0d want 1", cnt8);
        else n_pass++;
    endtask

    task automatic test_wrap_up();
        logic [7:0] exp_cnt [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
        do_reset();
        en = 1; up = 1; mode = 2'd0; lim = 32'd5;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({cnt8, tc8, ovf8} !== {exp_cnt[i], i == 5, i == 5}) begin
                $display("FAIL wrap_up[%0d]: got cnt=%0d tc=%b ovf=%b want cnt=%0d tc=%b ovf=%b",
                         i, cnt8, tc8, ovf8, exp_cnt[i], i == 5, i == 5);
            end else n_pass++;
        end
        tick();
        n_checks++;
        if ({cnt8, tc8, ovf8} !== {8'd1, 1'b0, 1'b1}) begin
            $display("FAIL wrap_after: got cnt=%0d tc=%b ovf=%b want 1 0 1",
                     cnt8, tc8, ovf8);
        end else n_pass++;
    endtask

    task automatic test_sat_down();
        logic [7:0] exp_cnt [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
        logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        load = 1; lv = 32'd2; mode = 2'd1; up = 0; en = 1;
        tick();
        n_checks++;
        if ({cnt8, tc8} !== {8'd2, 1'b0}) begin
            $display("FAIL sat_load: got cnt=%0d tc=%b want 2 0", cnt8, tc8);
        end else n_pass++;
        load = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({cnt8, tc8, ovf8} !== {exp_cnt[i], exp_tc[i], 1'b0}) begin
                $display("FAIL sat_down[%0d]: got cnt=%0d tc=%b ovf=%b want cnt=%0d tc=%b ovf=0",
                         i, cnt8, tc8, ovf8, exp_cnt[i], exp_tc[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        mode = 2'd2; lim = 32'd3; up = 1; en = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if ({cnt8, tc8, done8} !== {(i < 4) ? i[7:0] : 8'd3, i == 4, i == 4}) begin
                $display("FAIL oneshot_run[%0d]: got cnt=%0d tc=%b done=%b", i, cnt8, tc8, done8);
            end else n_pass++;
        end
        // DONE ignores enable, direction and mode.
        for (int i = 0; i < 4; i++) begin
            en = i[0]; up = $urandom_range(0, 1); mode = 2'($urandom_range(0, 3));
            tick();
            n_checks++;
            if ({cnt8, tc8, done8} !== {8'd3, 1'b0, 1'b1}) begin
                $display("FAIL oneshot_hold[%0d]: got cnt=%0d tc=%b done=%b want 3 0 1",
                         i, cnt8, tc8, done8);
            end else n_pass++;
        end
        mode = 2'd2; up = 1; en = 1; load = 1; lv = 32'd1;
        tick();
        n_checks++;
        if ({cnt8, tc8, done8} !== {8'd1, 1'b0, 1'b0}) begin
            $display("FAIL oneshot_reload: got cnt=%0d tc=%b done=%b want 1 0 0", cnt8, tc8, done8);
        end else n_pass++;
        load = 0;
        tick(); tick();
        n_checks++;
        if ({cnt8, done8} !== {8'd3, 1'b0}) begin
            $display("FAIL oneshot_resume: got cnt=%0d done=%b want 3 0", cnt8, done8);
        end else n_pass++;
        tick();
        n_checks++;
        if ({cnt8, tc8, done8} !== {8'd3, 1'b1, 1'b1}) begin
            $display("FAIL oneshot_again: got cnt=%0d tc=%b done=%b want 3 1 1", cnt8, tc8, done8);
        end else n_pass++;
    endtask

    task automatic test_priority();
        // Count 0 counting down is at the terminal; load still wins.
        do_reset();
        load = 1; en = 1; up = 0; mode = 2'd0; lv = 32'h40;
        tick();
        n_checks++;
        if ({cnt8, tc8, ovf8} !== {8'h40, 1'b0, 1'b0}) begin
            $display("FAIL load_over_en: got cnt=%0h tc=%b ovf=%b want 40 0 0", cnt8, tc8, ovf8);
        end else n_pass++;
    endtask

    task automatic test_sticky();
        do_reset();
        en = 1; up = 1; mode = 2'd0; lim = 32'd0; clr = 1;
        tick();
        n_checks++;
        if ({cnt8, tc8, ovf8} !== {8'd0, 1'b1, 1'b1}) begin
            $display("FAIL ovf_set_wins: got cnt=%0d tc=%b ovf=%b want 0 1 1", cnt8, tc8, ovf8);
        end else n_pass++;
        en = 0;
        tick();
        n_checks++;
        if ({tc8, ovf8} !== 2'b00) begin
            $display("FAIL ovf_clear: got tc=%b ovf=%b want 0 0", tc8, ovf8);
        end else n_pass++;
        // Limit 0 with held enable: a terminal event every cycle.
        en = 1; clr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({cnt8, tc8, ovf8} !== {8'd0, 1'b1, 1'b1}) begin
                $display("FAIL tc_continuous[%0d]: got cnt=%0d tc=%b ovf=%b want 0 1 1",
                         i, cnt8, tc8, ovf8);
            end else n_pass++;
        end
    endtask

    task automatic test_limit_below();
        do_reset();
        load = 1; lv = 32'd254;
        tick();
        load = 0; en = 1; up = 1; mode = 2'd0; lim = 32'd5;
        tick();
        n_checks++;
        if ({cnt8, tc8, ovf8} !== {8'd255, 1'b0, 1'b0}) begin
            $display("FAIL above_limit: got cnt=%0d tc=%b ovf=%b want 255 0 0", cnt8, tc8, ovf8);
        end else n_pass++;
        tick();
        n_checks++;
        if ({cnt8, tc8, ovf8} !== {8'd0, 1'b0, 1'b0}) begin
            $display("FAIL rollover: got cnt=%0d tc=%b ovf=%b want 0 0 0", cnt8, tc8, ovf8);
        end else n_pass++;
    endtask

    task automatic test_full_width();
        do_reset();
        load = 1; lv = 32'hFFFF_FFFE;
        tick();
        load = 0; en = 1; up = 1; mode = 2'd0; lim = 32'hFFFF_FFFF;
        tick();
        n_checks++;
        if ({cnt32, tc32, ovf32} !== {32'hFFFF_FFFF, 1'b0, 1'b0}) begin
            $display("FAIL full_max: got cnt=%0h tc=%b ovf=%b want ffffffff 0 0", cnt32, tc32, ovf32);
        end else n_pass++;
        tick();
        n_checks++;
        if ({cnt32, tc32, ovf32} !== {32'h0, 1'b1, 1'b1}) begin
            $display("FAIL full_wrap: got cnt=%0h tc=%b ovf=%b want 0 1 1", cnt32, tc32, ovf32);
        end else n_pass++;
        en = 0;
        tick();
        n_checks++;
        if ({cnt32, tc32, ovf32} !== {32'h0, 1'b0, 1'b1}) begin
            $display("FAIL full_after: got cnt=%0h tc=%b ovf=%b want 0 0 1", cnt32, tc32, ovf32);
        end else n_pass++;
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 63) == 0);
            load = ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1);
            mode = 2'($urandom_range(0, 3));
            clr  = !load && ($urandom_range(0, 7) == 0);
            lim  = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 12);
            lv   = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 15);
            tick();
            n_checks++;
            if ({cnt8, tc8, done8, ovf8} !==
                {m8.count[7:0], m8.tc, m8.done, m8.ovf}) begin
                if (bad < 10)
                    $display("FAIL rand8[%0d]: got cnt=%0h tc=%b done=%b ovf=%b want cnt=%0h tc=%b done=%b ovf=%b",
                             i, cnt8, tc8, done8, ovf8, m8.count[7:0], m8.tc, m8.done, m8.ovf);
                bad++;
            end else n_pass++;
            n_checks++;
            if ({cnt32, tc32, done32, ovf32} !==
                {m32.count[31:0], m32.tc, m32.done, m32.ovf}) begin
                if (bad < 10)
                    $display("FAIL rand32[%0d]: got cnt=%0h tc=%b done=%b ovf=%b want cnt=%0h tc=%b done=%b ovf=%b",
                             i, cnt32, tc32, done32, ovf32, m32.count[31:0], m32.tc, m32.done, m32.ovf);
                bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_oneshot();
        test_priority();
        test_sticky();
        test_limit_below();
        test_full_width();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
